sbc_mem_responder: RTL and testbench

- Memory-side responder for the single-cycle RV32 core on the SBC.
- Serves the core's instruction-fetch port (9-bit word address) and data port (5-bit address) with asynchronous reads and a synchronous data write.
- Contains a byte-serial program loader driven from the host/logic-analyzer side. The loader fills IMEM with a valid/ready handshake.
- Sequences the core: holds it in reset and injects NOPs until a load completes, then releases it.

---
 rtl/sbc_mem_responder_if.sv | 50 +++++
 rtl/sbc_mem_responder.sv | 135 +++++++++++++
 tb/tb_sbc_mem_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sbc_mem_responder_if.sv
// Bus bundle between the SBC memory responder and its core/host side.
// The load_checksum signal exists only when SBC_LOAD_CHECKSUM_EN is defined.
interface sbc_mem_responder_if #(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 32
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    logic [IA-1:0]    ins_mem_addr;
    logic [WIDTH-1:0] ins_mem_data;
    logic [DA-1:0]    data_mem_addr;
    logic             data_mem_wen;
    logic [WIDTH-1:0] data_mem_wdata;
    logic [WIDTH-1:0] data_mem_rdata;
    logic             load_start;
    logic [IA-1:0]    load_len;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             ins_mem_en;
    logic             cpu_reset_n;
    logic             load_done;
    logic [IA-1:0]    load_count;
`ifdef SBC_LOAD_CHECKSUM_EN
    logic [WIDTH-1:0] load_checksum;
`endif

    // master = core + host side, slave = the responder
    modport master (
`ifdef SBC_LOAD_CHECKSUM_EN
        input  load_checksum,
`endif
        output ins_mem_addr, data_mem_addr, data_mem_wen, data_mem_wdata,
        output load_start, load_len, byte_valid, byte_data,
        input  ins_mem_data, data_mem_rdata, byte_ready, ins_mem_en,
        input  cpu_reset_n, load_done, load_count
    );

    modport slave (
`ifdef SBC_LOAD_CHECKSUM_EN
        output load_checksum,
`endif
        input  ins_mem_addr, data_mem_addr, data_mem_wen, data_mem_wdata,
        input  load_start, load_len, byte_valid, byte_data,
        output ins_mem_data, data_mem_rdata, byte_ready, ins_mem_en,
        output cpu_reset_n, load_done, load_count
    );
endinterface

// File: rtl/sbc_mem_responder.sv
// SBC memory responder: IMEM/DMEM for the RV32 core plus a byte-serial IMEM loader
// that holds the core in reset until a load completes. Optional SBC_LOAD_CHECKSUM_EN.
module sbc_mem_responder #(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    sbc_mem_responder_if.slave  bus
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    typedef enum logic [1:0] {HALT = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

    state_t           state_reg;
    logic [IA-1:0]    len_reg;
    logic [IA-1:0]    word_addr_reg;
    logic [IA-1:0]    load_count_reg;
    logic [1:0]       byte_cnt_reg;
    logic [23:0]      lane_reg;
    logic [23:0]      lane_next;
    logic             byte_ready_reg;
    logic             ins_mem_en_reg;
    logic             cpu_reset_n_reg;
    logic             load_done_reg;

    logic [WIDTH-1:0] imem [IMEM_DEPTH];
    logic [WIDTH-1:0] dmem [DMEM_DEPTH];

    logic             byte_fire;
    logic             word_fire;
    logic [IA-1:0]    count_inc;
    logic [WIDTH-1:0] word_assembled;

    // A load_start cycle swallows any byte presented alongside it.
    assign byte_fire = (state_reg == LOAD) && bus.byte_valid && byte_ready_reg &&
                       !bus.load_start && (load_count_reg != len_reg);
    assign word_fire      = byte_fire && (byte_cnt_reg == 2'd3);
    assign count_inc      = load_count_reg + 1'b1;
    assign word_assembled = {bus.byte_data, lane_reg};

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        assign lane_next[gi*8 +: 8] = (byte_fire && byte_cnt_reg == 2'(gi)) ?
                                      bus.byte_data : lane_reg[gi*8 +: 8];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= HALT;
            len_reg         <= '0;
            word_addr_reg   <= '0;
            load_count_reg  <= '0;
            byte_cnt_reg    <= '0;
            lane_reg        <= '0;
            byte_ready_reg  <= 1'b0;
            ins_mem_en_reg  <= 1'b1;
            cpu_reset_n_reg <= 1'b0;
            load_done_reg   <= 1'b0;
        end else if (bus.load_start) begin
            state_reg       <= LOAD;
            len_reg         <= bus.load_len;
            word_addr_reg   <= '0;
            load_count_reg  <= '0;
            byte_cnt_reg    <= '0;
            byte_ready_reg  <= 1'b1;
            ins_mem_en_reg  <= 1'b1;
            cpu_reset_n_reg <= 1'b0;
            load_done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_count_reg == len_reg) begin
                        // zero-length load: one LOAD cycle, then release the core
                        state_reg       <= RUN;
                        byte_ready_reg  <= 1'b0;
                        ins_mem_en_reg  <= 1'b0;
                        cpu_reset_n_reg <= 1'b1;
                        load_done_reg   <= 1'b1;
                    end else if (byte_fire) begin
                        lane_reg <= lane_next;
                        if (word_fire) begin
                            byte_cnt_reg   <= '0;
                            word_addr_reg  <= word_addr_reg + 1'b1;
                            load_count_reg <= count_inc;
                            if (count_inc == len_reg) begin
                                state_reg       <= RUN;
                                byte_ready_reg  <= 1'b0;
                                ins_mem_en_reg  <= 1'b0;
                                cpu_reset_n_reg <= 1'b1;
                                load_done_reg   <= 1'b1;
                            end
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (word_fire)
            imem[word_addr_reg] <= word_assembled;
    end

    // The core strobe is only trusted once it is out of reset.
    always_ff @(posedge clock) begin
        if (state_reg == RUN && bus.data_mem_wen)
            dmem[bus.data_mem_addr] <= bus.data_mem_wdata;
    end

`ifdef SBC_LOAD_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_reg;

    always_ff @(posedge clock) begin
        if (!reset || bus.load_start)
            checksum_reg <= '0;
        else if (word_fire)
            checksum_reg <= checksum_reg + word_assembled;
    end

    assign bus.load_checksum = checksum_reg;
`endif

    assign bus.ins_mem_data   = imem[bus.ins_mem_addr];
    assign bus.data_mem_rdata = dmem[bus.data_mem_addr];
    assign bus.byte_ready     = byte_ready_reg;
    assign bus.ins_mem_en     = ins_mem_en_reg;
    assign bus.cpu_reset_n    = cpu_reset_n_reg;
    assign bus.load_done      = load_done_reg;
    assign bus.load_count     = load_count_reg;
endmodule

// File: tb/tb_sbc_mem_responder.sv
// Randomized self-checking bench for sbc_mem_responder against a byte-stream/array model.
// Checksum checks are active when SBC_LOAD_CHECKSUM_EN is defined.
module tb_sbc_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;

    sbc_mem_responder_if bus();

    sbc_mem_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_imem [512];
    bit          imem_known [512];
    logic [31:0] model_dmem [32];
    bit          dmem_known [32];
    logic [31:0] model_sum;
    logic [7:0]  byte_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_random(input int n);
        byte_q.delete();
        repeat (n) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_halt(input string tag);
        check({tag, "_ready"},  32'(bus.byte_ready), 32'd0);
        check({tag, "_nop"},    32'(bus.ins_mem_en), 32'd1);
        check({tag, "_cpurst"}, 32'(bus.cpu_reset_n), 32'd0);
        check({tag, "_done"},   32'(bus.load_done), 32'd0);
        check({tag, "_count"},  32'(bus.load_count), 32'd0);
`ifdef SBC_LOAD_CHECKSUM_EN
        check({tag, "_csum"},   bus.load_checksum, 32'd0);
`endif
    endtask

    // Begins a load; a junk byte is offered in the same cycle and must be ignored.
    task automatic start_load(input int len);
        bus.load_start = 1'b1;
        bus.load_len   = 9'(len);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        step();
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        model_sum      = 32'd0;
        check("start_count",  32'(bus.load_count), 32'd0);
        check("start_ready",  32'(bus.byte_ready), 32'd1);
        check("start_cpurst", 32'(bus.cpu_reset_n), 32'd0);
`ifdef SBC_LOAD_CHECKSUM_EN
        check("start_csum",   bus.load_checksum, 32'd0);
`endif
    endtask

    // gap_mode: 0 back-to-back, 1 valid toggles every other cycle, 2 random gaps
    task automatic feed(input int len, input int nbytes, input int gap_mode);
        for (int i = 0; i < nbytes; i++) begin
            bit gap;
            gap = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gap) begin
                bus.byte_valid = 1'b0;
                step();
                check("gap_ready", 32'(bus.byte_ready), 32'd1);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = byte_q[i];
            step();
            if (i % 4 == 3) begin
                int w;
                logic [31:0] word;
                w = i / 4;
                word = 32'(byte_q[i-3]) + (32'(byte_q[i-2]) << 8) +
                       (32'(byte_q[i-1]) << 16) + (32'(byte_q[i]) << 24);
                model_imem[w] = word;
                imem_known[w] = 1'b1;
                model_sum     = model_sum + word;
                if (w + 1 < len) begin
                    check("mid_count", 32'(bus.load_count), 32'(w + 1));
                    check("mid_ready", 32'(bus.byte_ready), 32'd1);
                end
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_imem(input int n);
        for (int w = 0; w < n; w++) begin
            if (imem_known[w]) begin
                bus.ins_mem_addr = 9'(w);
                #1;
                check("imem_rd", bus.ins_mem_data, model_imem[w]);
            end
        end
    endtask

    task automatic do_load(input int len, input int gap_mode);
        start_load(len);
        if (len == 0) step();
        else feed(len, len * 4, gap_mode);
        check("run_ready",  32'(bus.byte_ready), 32'd0);
        check("run_nop",    32'(bus.ins_mem_en), 32'd0);
        check("run_cpurst", 32'(bus.cpu_reset_n), 32'd1);
        check("run_done",   32'(bus.load_done), 32'd1);
        check("run_count",  32'(bus.load_count), 32'(len));
`ifdef SBC_LOAD_CHECKSUM_EN
        check("run_csum",   bus.load_checksum, model_sum);
`endif
        check_imem(len);
        $display("[TB] load len=%0d gap_mode=%0d", len, gap_mode);
    endtask

    task automatic dmem_write(input int addr, input logic [31:0] data, input bit in_run);
        bus.data_mem_addr  = 5'(addr);
        bus.data_mem_wdata = data;
        bus.data_mem_wen   = 1'b1;
        #1;
        if (dmem_known[addr]) check("dmem_old", bus.data_mem_rdata, model_dmem[addr]);
        step();
        bus.data_mem_wen = 1'b0;
        if (in_run) begin
            model_dmem[addr] = data;
            dmem_known[addr] = 1'b1;
        end
        #1;
        if (dmem_known[addr]) check("dmem_new", bus.data_mem_rdata, model_dmem[addr]);
        $display("[TB] dmem write addr=%0d data=0x%08h run=%0d", addr, data, in_run);
    endtask

    initial begin
        bus.ins_mem_addr   = '0;
        bus.data_mem_addr  = '0;
        bus.data_mem_wen   = 1'b0;
        bus.data_mem_wdata = '0;
        bus.load_start     = 1'b0;
        bus.load_len       = '0;
        bus.byte_valid     = 1'b0;
        bus.byte_data      = '0;

        // reset held two cycles, then idle in HALT
        step();
        step();
        reset = 1'b1;
        check_halt("rst");
        step();
        check_halt("halt_idle");

        // two-word program, back-to-back bytes
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h50, 8'h00};
        do_load(2, 0);
        bus.ins_mem_addr = 9'd0;
        #1;
        check("prog_w0", bus.ins_mem_data, 32'h0000_0013);
        bus.ins_mem_addr = 9'd1;
        #1;
        check("prog_w1", bus.ins_mem_data, 32'h0050_0193);
`ifdef SBC_LOAD_CHECKSUM_EN
        check("prog_csum", bus.load_checksum, 32'h0050_01A6);
`endif

        // same program with byte_valid toggling
        do_load(2, 1);

        // DMEM read-during-write in RUN
        dmem_write(5, 32'h1111_1111, 1'b1);
        bus.data_mem_wdata = 32'hDEAD_BEEF;
        bus.data_mem_wen   = 1'b1;
        #1;
        check("dmem_rdw_old", bus.data_mem_rdata, 32'h1111_1111);
        step();
        bus.data_mem_wen = 1'b0;
        #1;
        check("dmem_rdw_new", bus.data_mem_rdata, 32'hDEAD_BEEF);
        model_dmem[5] = 32'hDEAD_BEEF;

        // reset after 6 of 8 bytes: word 0 replaced, word 1 untouched
        fill_random(8);
        start_load(2);
        feed(2, 6, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_halt("midload_rst");
        check_imem(2);

        // DMEM strobe in HALT must not write
        dmem_write(5, 32'h0BAD_F00D, 1'b0);

        // zero-length load
        do_load(0, 0);

        // reload while LOAD is in progress
        fill_random(12);
        start_load(3);
        feed(3, 5, 2);
        fill_random(4);
        do_load(1, 2);

        // randomized loads with random DMEM traffic in RUN
        repeat (6) begin
            int len;
            len = $urandom_range(1, 16);
            fill_random(len * 4);
            do_load(len, 2);
            repeat (4) dmem_write($urandom_range(0, 31), $urandom, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
